// File: rtl/ip_csum_fixup.sv
// ip_csum_fixup: recomputes the IPv4 header checksum of each packet on a 256-bit AXI-Stream.
// Ports: AXI_ACLK/AXI_RESET clock and async active-high reset; S_AXIS_* input stream;
// M_AXIS_* output stream; clear_counters sync counter clear; csum_fixed_count counts
// fixed IPv4 packets; ttl_drop_count counts TTL=0 drops (IP_CSUM_TTL_DROP_EN only, else 0).
// Beats 0 and 1 are held so the checksum over bytes 14..33 can be patched into beat 0.
module ip_csum_fixup #(
  parameter int C_M_AXIS_DATA_WIDTH = 256,
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              clear_counters,
  output logic [31:0]                       csum_fixed_count,
  output logic [31:0]                       ttl_drop_count
);
  if (C_S_AXIS_DATA_WIDTH != 256 || C_M_AXIS_DATA_WIDTH != 256 ||
      DST_PORT_POS + 8 > C_S_AXIS_TUSER_WIDTH) begin : g_bad_cfg
    $error("ip_csum_fixup supports only 256-bit data with the port one-hot inside TUSER");
  end
  localparam logic [2:0] IDLE = 3'd0, HOLD = 3'd1, EMIT0 = 3'd2, EMIT1 = 3'd3, PASS = 3'd4;
`ifdef IP_CSUM_TTL_DROP_EN
  localparam logic [2:0] DROP = 3'd5;
`endif
  logic [2:0]   state;
  logic [255:0] h0_data, h1_data;
  logic [31:0]  h0_strb, h1_strb;
  logic [127:0] h0_user, h1_user;
  logic         h0_last, h1_last, h0_ip, is_ip, drop_st, ttl_zero;
  logic [19:0]  sum;
  logic [16:0]  fold;
  logic [15:0]  csum;
  assign is_ip = S_AXIS_TDATA[159:144] == 16'h0800 && S_AXIS_TDATA[143:136] == 8'h45 && !S_AXIS_TLAST;
  assign ttl_zero = h0_data[79:72] == 8'h00;
`ifdef IP_CSUM_TTL_DROP_EN
  assign drop_st = state == DROP;
`else
  assign drop_st = 1'b0;
`endif
  assign S_AXIS_TREADY = !AXI_RESET && (state == IDLE || state == HOLD || drop_st ||
                                        (state == PASS && M_AXIS_TREADY));
  assign M_AXIS_TVALID = state == EMIT0 || state == EMIT1 || (state == PASS && S_AXIS_TVALID);
  assign M_AXIS_TDATA = state == PASS ? S_AXIS_TDATA : state == EMIT1 ? h1_data : h0_data;
  assign M_AXIS_TSTRB = state == PASS ? S_AXIS_TSTRB : state == EMIT1 ? h1_strb : h0_strb;
  assign M_AXIS_TUSER = state == PASS ? S_AXIS_TUSER : state == EMIT1 ? h1_user : h0_user;
  assign M_AXIS_TLAST = state == PASS ? S_AXIS_TLAST : state == EMIT1 ? h1_last : h0_last;
  // Header words 14..31 come from H0, the old checksum word (bytes 24..25) is skipped,
  // and bytes 32..33 come from the beat being latched into H1 this cycle.
  always_comb begin
    sum = {4'b0, S_AXIS_TDATA[255:240]};
    for (int i = 0; i < 9; i++)
      if (i != 5) sum = sum + {4'b0, h0_data[143-16*i -: 16]};
    fold = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    csum = ~(fold[15:0] + {15'b0, fold[16]});
  end
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET)
    if (AXI_RESET) begin
      state <= IDLE;
      {h0_data, h0_strb, h0_user, h0_last, h0_ip} <= '0;
      {h1_data, h1_strb, h1_user, h1_last} <= '0;
    end else begin
      case (state)
        IDLE: if (S_AXIS_TVALID) begin
          {h0_data, h0_strb, h0_user, h0_last} <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
          h0_ip <= is_ip;
          state <= is_ip ? HOLD : EMIT0;
        end
        HOLD: if (S_AXIS_TVALID) begin
          {h1_data, h1_strb, h1_user, h1_last} <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
          h0_data[63:48] <= csum;
`ifdef IP_CSUM_TTL_DROP_EN
          state <= !ttl_zero ? EMIT0 : S_AXIS_TLAST ? IDLE : DROP;
`else
          state <= EMIT0;
`endif
        end
        EMIT0: if (M_AXIS_TREADY) state <= h0_last ? IDLE : h0_ip ? EMIT1 : PASS;
        EMIT1: if (M_AXIS_TREADY) state <= h1_last ? IDLE : PASS;
        PASS: if (S_AXIS_TVALID && M_AXIS_TREADY && S_AXIS_TLAST) state <= IDLE;
`ifdef IP_CSUM_TTL_DROP_EN
        DROP: if (S_AXIS_TVALID && S_AXIS_TLAST) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET)
    if (AXI_RESET) csum_fixed_count <= '0;
    else if (clear_counters) csum_fixed_count <= '0;
    else if (state == EMIT0 && M_AXIS_TREADY && h0_ip) csum_fixed_count <= csum_fixed_count + 32'd1;
`ifdef IP_CSUM_TTL_DROP_EN
  always_ff @(posedge AXI_ACLK or posedge AXI_RESET)
    if (AXI_RESET) ttl_drop_count <= '0;
    else if (clear_counters) ttl_drop_count <= '0;
    else if (state == HOLD && S_AXIS_TVALID && ttl_zero) ttl_drop_count <= ttl_drop_count + 32'd1;
`else
  assign ttl_drop_count = 32'd0;
`endif
endmodule

// File: tb/tb_ip_csum_fixup.sv
// tb_ip_csum_fixup: table-driven, hand-sequenced and randomized checks of ip_csum_fixup.
module tb_ip_csum_fixup;
  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;
  typedef struct {
    logic [15:0]  et;
    logic [143:0] hdr;
    logic [15:0]  w;
    int           nb;
    logic [15:0]  exp;
    int           inc;
  } vec_t;
  logic         AXI_ACLK = 0, AXI_RESET = 1, clear_counters = 0;
  logic [255:0] S_AXIS_TDATA, M_AXIS_TDATA;
  logic [31:0]  S_AXIS_TSTRB, M_AXIS_TSTRB, csum_fixed_count, ttl_drop_count;
  logic [127:0] S_AXIS_TUSER, M_AXIS_TUSER;
  logic         S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic         M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  int checks = 0, failures = 0, exp_csum = 0, exp_drop = 0;
  bit rdy_rand = 0, rdy_force = 1, vld_rand = 0, s_hs = 0;
  beat_t in_q[$], exp_q[$], out_q[$], pkt_q[$];
  vec_t tbl[5];
  ip_csum_fixup dut (
    .AXI_ACLK(AXI_ACLK), .AXI_RESET(AXI_RESET),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .clear_counters(clear_counters), .csum_fixed_count(csum_fixed_count), .ttl_drop_count(ttl_drop_count)
  );
  always #5 AXI_ACLK = ~AXI_ACLK;
  always @(negedge AXI_ACLK) begin
    s_hs <= S_AXIS_TVALID && S_AXIS_TREADY;
    if (M_AXIS_TVALID && M_AXIS_TREADY) out_q.push_back({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST});
  end
  initial begin
    S_AXIS_TVALID = 0;
    {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST} = '0;
    M_AXIS_TREADY = 0;
    forever begin
      @(posedge AXI_ACLK);
      #1;
      if (s_hs) begin
        in_q.delete(0);
        S_AXIS_TVALID = 0;
      end
      if (!S_AXIS_TVALID && in_q.size() > 0) S_AXIS_TVALID = vld_rand ? $urandom_range(0, 3) != 0 : 1'b1;
      if (S_AXIS_TVALID) {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST} = in_q[0];
      M_AXIS_TREADY = rdy_rand ? $urandom_range(0, 3) != 0 : rdy_force;
    end
  end
  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  // Reference checksum: byte-pair sum over the IPv4 header with end-around carry.
  function automatic logic [15:0] ref_csum(input logic [255:0] b0, input logic [255:0] b1);
    int s = 0;
    logic [15:0] w;
    for (int n = 14; n < 34; n += 2) begin
      w = n < 32 ? b0[255-8*n -: 16] : b1[255-8*(n-32) -: 16];
      if (n != 24) s += int'(w);
    end
    while (s > 65535) s = (s & 65535) + (s >> 16);
    return ~s[15:0];
  endfunction
  function automatic beat_t rnd_beat();
    beat_t b;
    b.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.s = $urandom;
    b.u = {$urandom, $urandom, $urandom, $urandom};
    b.l = 0;
    return b;
  endfunction
  task automatic build(input logic [15:0] et, input logic [7:0] vihl, input logic [7:0] ttl, input int nb);
    beat_t b;
    pkt_q.delete();
    for (int i = 0; i < nb; i++) begin
      b = rnd_beat();
      b.l = i == nb - 1;
      if (i == 0) begin
        b.d[159:144] = et;
        b.d[143:136] = vihl;
        b.d[79:72] = ttl;
      end
      pkt_q.push_back(b);
    end
  endtask
  task automatic add_pkt();
    beat_t b0;
    bit ip, drop;
    b0 = pkt_q[0];
    ip = b0.d[159:144] == 16'h0800 && b0.d[143:136] == 8'h45 && !b0.l;
`ifdef IP_CSUM_TTL_DROP_EN
    drop = ip && b0.d[79:72] == 8'h00;
`else
    drop = 0;
`endif
    foreach (pkt_q[i]) in_q.push_back(pkt_q[i]);
    if (drop) exp_drop++;
    else begin
      if (ip) begin
        b0.d[63:48] = ref_csum(pkt_q[0].d, pkt_q[1].d);
        exp_csum++;
      end
      exp_q.push_back(b0);
      for (int i = 1; i < pkt_q.size(); i++) exp_q.push_back(pkt_q[i]);
    end
  endtask
  task automatic drain();
    int t = 0;
    beat_t a, e;
    while ((in_q.size() != 0 || out_q.size() < exp_q.size()) && t < 3000) begin
      @(negedge AXI_ACLK);
      t++;
    end
    repeat (6) @(negedge AXI_ACLK);
    chk(t < 3000 && out_q.size() == exp_q.size(), "beat_count", 256'(out_q.size()), 256'(exp_q.size()));
    while (out_q.size() > 0 && exp_q.size() > 0) begin
      a = out_q.pop_front();
      e = exp_q.pop_front();
      chk(a == e, "beat", a.d, e.d);
    end
    out_q.delete();
    exp_q.delete();
  endtask
  task automatic chk_counts();
    chk(csum_fixed_count == 32'(exp_csum), "csum_fixed_count", 256'(csum_fixed_count), 256'(exp_csum));
    chk(ttl_drop_count == 32'(exp_drop), "ttl_drop_count", 256'(ttl_drop_count), 256'(exp_drop));
  endtask
  initial begin
    int t, c0;
    bit ok;
    beat_t b;
    tbl[0] = '{16'h0800, 144'h4500_0073_0000_4000_3F11_B861_C0A8_0001_C0A8, 16'h00C7, 3, 16'hB961, 1};
    tbl[1] = '{16'h0806, 144'h4500_0073_0000_4000_3F11_B861_C0A8_0001_C0A8, 16'h00C7, 2, 16'hB861, 0};
    tbl[2] = '{16'h0800, 144'h4500_0073_0000_4000_3F11_B861_C0A8_0001_C0A8, 16'h00C7, 1, 16'hB861, 0};
    tbl[3] = '{16'h0800, 144'h4600_0073_0000_4000_3F11_B861_C0A8_0001_C0A8, 16'h00C7, 2, 16'hB861, 0};
    tbl[4] = '{16'h0800, 144'h4500_0000_0000_0000_0100_1234_0000_0000_0000, 16'h0000, 2, 16'hB9FF, 1};
    repeat (3) @(negedge AXI_ACLK);
    chk(S_AXIS_TREADY == 0, "reset_tready", 256'(S_AXIS_TREADY), 0);
    chk(M_AXIS_TVALID == 0, "reset_tvalid", 256'(M_AXIS_TVALID), 0);
    chk_counts();
    AXI_RESET = 0;
    rdy_rand = 1;
    vld_rand = 1;
    foreach (tbl[k]) begin
      build(tbl[k].et, 8'h45, 8'h3F, tbl[k].nb);
      b = pkt_q[0];
      b.d[143:0] = tbl[k].hdr;
      pkt_q[0] = b;
      if (tbl[k].nb > 1) begin
        b = pkt_q[1];
        b.d[255:240] = tbl[k].w;
        pkt_q[1] = b;
      end
      c0 = int'(csum_fixed_count);
      add_pkt();
      t = 0;
      while (out_q.size() == 0 && t < 500) begin
        @(negedge AXI_ACLK);
        t++;
      end
      b = out_q.size() > 0 ? out_q[0] : '0;
      chk(b.d[63:48] == tbl[k].exp, "vec_bytes24_25", 256'(b.d[63:48]), 256'(tbl[k].exp));
      drain();
      chk(int'(csum_fixed_count) - c0 == tbl[k].inc, "vec_count_inc", 256'(csum_fixed_count), 256'(c0 + tbl[k].inc));
    end
    rdy_rand = 0;
    rdy_force = 1;
    vld_rand = 0;
    build(16'h0800, 8'h45, 8'h40, 1);
    add_pkt();
    t = 0;
    do begin
      @(negedge AXI_ACLK);
      t++;
    end while (!(S_AXIS_TVALID && S_AXIS_TREADY) && t < 50);
    @(negedge AXI_ACLK);
    chk(M_AXIS_TVALID == 1, "latency_1beat", 256'(M_AXIS_TVALID), 1);
    drain();
    rdy_force = 0;
    build(16'h0800, 8'h45, 8'h40, 3);
    add_pkt();
    t = 0;
    while (!M_AXIS_TVALID && t < 50) begin
      @(negedge AXI_ACLK);
      t++;
    end
    ok = t < 50;
    repeat (10) begin
      @(negedge AXI_ACLK);
      ok &= !S_AXIS_TREADY && M_AXIS_TVALID && out_q.size() == 0;
    end
    chk(ok, "stall_emit0", 256'({S_AXIS_TREADY, M_AXIS_TVALID}), 256'(2'b01));
    rdy_rand = 1;
    drain();
    chk_counts();
    clear_counters = 1;
    build(16'h0800, 8'h45, 8'h22, 2);
    add_pkt();
    drain();
    clear_counters = 0;
    exp_csum = 0;
    exp_drop = 0;
    chk_counts();
    build(16'h0800, 8'h45, 8'h00, 3);
    add_pkt();
    build(16'h0800, 8'h45, 8'h11, 2);
    add_pkt();
    drain();
    chk_counts();
    rdy_rand = 0;
    rdy_force = 1;
    build(16'h0800, 8'h45, 8'h40, 3);
    in_q.push_back(pkt_q[0]);
    t = 0;
    while (in_q.size() != 0 && t < 50) begin
      @(negedge AXI_ACLK);
      t++;
    end
    @(negedge AXI_ACLK);
    AXI_RESET = 1;
    @(negedge AXI_ACLK);
    chk(!S_AXIS_TREADY && !M_AXIS_TVALID && t < 50, "reset_mid_pkt", 256'({S_AXIS_TREADY, M_AXIS_TVALID}), 0);
    AXI_RESET = 0;
    exp_csum = 0;
    exp_drop = 0;
    chk(out_q.size() == 0, "reset_no_output", 256'(out_q.size()), 0);
    build(16'h0800, 8'h45, 8'h40, 3);
    add_pkt();
    drain();
    chk_counts();
    rdy_rand = 1;
    vld_rand = 1;
    for (int n = 0; n < 40; n++) begin
      build($urandom_range(0, 2) == 0 ? 16'h0806 : 16'h0800, $urandom_range(0, 4) == 0 ? 8'h46 : 8'h45,
            $urandom_range(0, 5) == 0 ? 8'h00 : 8'($urandom_range(1, 255)), $urandom_range(1, 4));
      add_pkt();
    end
    drain();
    chk_counts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
